// File: rtl/mem_burst_responder_if.sv
// Cache-side handshake for mem_burst_responder. The 64-bit data bus stays a plain inout
// on the responder so that both ends can tri-state it.
interface mem_burst_responder_if;
    logic        req;
    logic        we_MEM;
    logic [31:0] addr_MEM;
    logic        stb;
    logic        busy;
    logic        done;

    modport master (output req, we_MEM, addr_MEM, input  stb, busy, done);
    modport slave  (input  req, we_MEM, addr_MEM, output stb, busy, done);
endinterface

// File: rtl/mem_burst_responder.sv
// Burst memory responder: 8-beat line bursts, one stb transition per beat, fixed access latency.
// Optional MEM_CRITICAL_WORD_FIRST_EN: bursts start at addr_MEM[5:3] and wrap within the line.
module mem_burst_responder #(
    parameter int unsigned ACCESS_LATENCY = 4,
    parameter int unsigned BEAT_GAP       = 1,
    parameter int unsigned MEM_LINES_LOG2 = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_burst_responder_if.slave bus,
    inout  wire  [63:0]          data_MEM
);
    localparam int unsigned AW    = MEM_LINES_LOG2 + 3;
    localparam int unsigned WORDS = 1 << AW;

    typedef enum logic [1:0] {IDLE, LATENCY, BEAT, DONE} state_t;
    state_t state, state_nxt;

    logic [3:0]                cnt;
    logic [3:0]                beat_cnt;
    logic [MEM_LINES_LOG2-1:0] line_q;
    logic                      we_q;
    logic                      stb_q;
    logic                      drive_q;
    logic [63:0]               rd_q;
    logic                      cnt_zero;
    logic                      beat_fire;
    logic                      last_gap;
    logic [2:0]                word_off;
    logic [AW-1:0]             word_addr;
    logic [63:0]               mem [WORDS];

`ifdef MEM_CRITICAL_WORD_FIRST_EN
    logic [2:0] start_q;
    logic       unused_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            start_q <= '0;
        else if (state == IDLE && bus.req)
            start_q <= bus.addr_MEM[5:3];
    end

    assign word_off    = start_q + beat_cnt[2:0];
    assign unused_addr = ^{bus.addr_MEM[31:MEM_LINES_LOG2+6], bus.addr_MEM[2:0]};
`else
    logic unused_addr;

    assign word_off    = beat_cnt[2:0];
    assign unused_addr = ^{bus.addr_MEM[31:MEM_LINES_LOG2+6], bus.addr_MEM[5:0]};
`endif

    assign word_addr = {line_q, word_off};
    assign cnt_zero  = (cnt == 4'd0);
    // beat_cnt counts completed beats; reaching 8 leaves one final gap before DONE
    assign beat_fire = cnt_zero && ((state == LATENCY) || (state == BEAT && !beat_cnt[3]));
    assign last_gap  = cnt_zero && (state == BEAT) && beat_cnt[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = LATENCY;
            LATENCY: if (cnt_zero) state_nxt = BEAT;
            BEAT:    if (last_gap) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.stb  = stb_q;
        bus.busy = (state == LATENCY) || (state == BEAT);
        bus.done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            beat_cnt <= '0;
            line_q   <= '0;
            we_q     <= 1'b0;
            stb_q    <= 1'b0;
            drive_q  <= 1'b0;
            rd_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        cnt      <= 4'(ACCESS_LATENCY - 1);
                        beat_cnt <= '0;
                        line_q   <= bus.addr_MEM[MEM_LINES_LOG2+5:6];
                        we_q     <= bus.we_MEM;
                    end
                end
                LATENCY, BEAT: begin
                    cnt <= cnt_zero ? 4'(BEAT_GAP - 1) : cnt - 4'd1;
                    if (beat_fire) begin
                        stb_q    <= ~stb_q;
                        beat_cnt <= beat_cnt + 4'd1;
                        if (we_q) begin
                            drive_q <= 1'b1;
                            rd_q    <= mem[word_addr];
                        end
                    end
                    if (last_gap)
                        drive_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // storage is deliberately outside reset so aborted bursts keep completed writes
    always_ff @(posedge clk) begin
        if (beat_fire && !we_q)
            mem[word_addr] <= data_MEM;
    end

`ifndef SYNTHESIS
    initial begin
        for (int unsigned i = 0; i < WORDS; i++)
            mem[i] = 64'(i);
    end
`endif

    assign data_MEM = drive_q ? rd_q : 'z;
endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: default instance plus a latency 1 / gap 3 instance.
module tb_mem_burst_responder;
    localparam logic [63:0] MARK = 64'hA5A5_A5A5_A5A5_A5A0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic        sel;
    logic        tb_drv;
    logic [31:0] addr;
    logic [63:0] tb_data;
    wire  [63:0] data0;
    wire  [63:0] data1;

    always #5 clk = ~clk;

    mem_burst_responder_if bus0 ();
    mem_burst_responder_if bus1 ();

    assign bus0.req      = req & ~sel;
    assign bus0.we_MEM   = we;
    assign bus0.addr_MEM = addr;
    assign bus1.req      = req & sel;
    assign bus1.we_MEM   = we;
    assign bus1.addr_MEM = addr;
    assign data0 = (tb_drv && !sel) ? tb_data : 'z;
    assign data1 = (tb_drv &&  sel) ? tb_data : 'z;

    mem_burst_responder dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus0),
        .data_MEM (data0)
    );

    mem_burst_responder #(.ACCESS_LATENCY(1), .BEAT_GAP(3)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus1),
        .data_MEM (data1)
    );

    wire        stb_s  = sel ? bus1.stb  : bus0.stb;
    wire        busy_s = sel ? bus1.busy : bus0.busy;
    wire        done_s = sel ? bus1.done : bus0.done;
    wire [63:0] data_s = sel ? data1     : data0;

    int          errors = 0;
    int          checks = 0;
    logic        busy_a [64];
    logic        done_a [64];
    int          tog_c  [32];
    logic [63:0] tog_d  [32];
    int          ntog;
    logic [63:0] wbuf   [8];

    // Cycle 0 is the edge where req is first seen; records busy/done and each stb transition.
    task automatic run(input int n, input bit hold);
        logic prev;
        prev = stb_s;
        ntog = 0;
        for (int c = 0; c <= n; c++) begin
            @(posedge clk); #1;
            if (c == 0 && !hold) req = 1'b0;
            busy_a[c] = busy_s;
            done_a[c] = done_s;
            if (stb_s !== prev) begin
                prev = stb_s;
                if (ntog < 32) begin
                    tog_c[ntog] = c;
                    tog_d[ntog] = data_s;
                end
                ntog++;
                if (tb_drv && ntog < 8) tb_data = wbuf[ntog];
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; req = 1'b0; we = 1'b1; addr = '0; tb_drv = 1'b0; tb_data = '0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus0.stb !== 1'b0)  begin errors++; $display("FAIL reset_stb0 got %b want 0", bus0.stb); end
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b want 0", bus0.busy); end
        checks++; if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done0 got %b want 0", bus0.done); end
        checks++; if (bus1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b want 0", bus1.busy); end
        req = 1'b1; we = 1'b1; addr = 32'h0000_0040;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus0.busy !== 1'b0) begin errors++; $display("FAIL reset_no_accept got %b want 0", bus0.busy); end
        tb_data = MARK; tb_drv = 1'b1; #1;
        checks++; if (data0 !== MARK) begin errors++; $display("FAIL reset_bus_released got %h want %h", data0, MARK); end
        tb_drv = 1'b0;
    endtask

    task automatic test_read();
        @(negedge clk);
        rst_n = 1'b1;
        run(16, 1'b0);
        checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL read_first_accept got %b want 1", busy_a[0]); end
        checks++; if (ntog !== 8) begin errors++; $display("FAIL read_toggles got %0d want 8", ntog); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (tog_c[k] !== 4 + k) begin errors++; $display("FAIL read_tog_cycle[%0d] got %0d want %0d", k, tog_c[k], 4 + k); end
            checks++; if (tog_d[k] !== 64'(8 + k)) begin errors++; $display("FAIL read_data[%0d] got %h want %h", k, tog_d[k], 64'(8 + k)); end
        end
        checks++; if (busy_a[11] !== 1'b1) begin errors++; $display("FAIL read_busy11 got %b want 1", busy_a[11]); end
        checks++; if (done_a[11] !== 1'b0) begin errors++; $display("FAIL read_done11 got %b want 0", done_a[11]); end
        checks++; if (done_a[12] !== 1'b1) begin errors++; $display("FAIL read_done12 got %b want 1", done_a[12]); end
        checks++; if (busy_a[12] !== 1'b0) begin errors++; $display("FAIL read_busy12 got %b want 0", busy_a[12]); end
        checks++; if (done_a[13] !== 1'b0) begin errors++; $display("FAIL read_done13 got %b want 0", done_a[13]); end
        checks++; if (stb_s !== 1'b0) begin errors++; $display("FAIL read_stb_end got %b want 0", stb_s); end
    endtask

    task automatic test_write_read();
        for (int k = 0; k < 8; k++) wbuf[k] = 64'(32'hA0 + k);
        addr = 32'h0000_0080; we = 1'b0; tb_data = wbuf[0]; tb_drv = 1'b1; req = 1'b1;
        run(16, 1'b0);
        tb_drv = 1'b0;
        checks++; if (ntog !== 8) begin errors++; $display("FAIL wr_toggles got %0d want 8", ntog); end
        checks++; if (done_a[12] !== 1'b1) begin errors++; $display("FAIL wr_done12 got %b want 1", done_a[12]); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (tog_d[k] !== 64'(32'hA0 + k)) begin errors++; $display("FAIL wr_bus[%0d] got %h want %h", k, tog_d[k], 64'(32'hA0 + k)); end
        end
        we = 1'b1; req = 1'b1;
        run(16, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++; if (tog_d[k] !== 64'(32'hA0 + k)) begin errors++; $display("FAIL wr_readback[%0d] got %h want %h", k, tog_d[k], 64'(32'hA0 + k)); end
        end
    endtask

    task automatic test_critical_word();
        logic [63:0] exp;
        addr = 32'h0000_0058; we = 1'b1; req = 1'b1;
        run(16, 1'b0);
        for (int k = 0; k < 8; k++) begin
`ifdef MEM_CRITICAL_WORD_FIRST_EN
            exp = 64'(8 + ((3 + k) % 8));
`else
            exp = 64'(8 + k);
`endif
            checks++; if (tog_d[k] !== exp) begin errors++; $display("FAIL cwf_data[%0d] got %h want %h", k, tog_d[k], exp); end
        end
    endtask

    task automatic test_back_to_back();
        addr = 32'h0000_0040; we = 1'b1; req = 1'b1;
        run(27, 1'b1);
        req = 1'b0;
        checks++; if (done_a[12] !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", done_a[12]); end
        checks++; if (busy_a[13] !== 1'b0) begin errors++; $display("FAIL b2b_idle13 got %b want 0", busy_a[13]); end
        checks++; if (busy_a[14] !== 1'b1) begin errors++; $display("FAIL b2b_accept14 got %b want 1", busy_a[14]); end
        checks++; if (done_a[26] !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", done_a[26]); end
        checks++; if (ntog !== 16) begin errors++; $display("FAIL b2b_toggles got %0d want 16", ntog); end
        checks++; if (tog_c[8] !== 18) begin errors++; $display("FAIL b2b_second_first got %0d want 18", tog_c[8]); end
        checks++; if (tog_d[15] !== 64'hF) begin errors++; $display("FAIL b2b_last_data got %h want f", tog_d[15]); end
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 0; k < 8; k++) wbuf[k] = 64'(32'hC0 + k);
        addr = 32'h0000_0080; we = 1'b0; tb_data = wbuf[0]; tb_drv = 1'b1; req = 1'b1;
        run(6, 1'b0);
        checks++; if (ntog !== 3) begin errors++; $display("FAIL abort_beats got %0d want 3", ntog); end
        rst_n = 1'b0; tb_drv = 1'b0;
        #1;
        checks++; if (stb_s !== 1'b0)  begin errors++; $display("FAIL abort_stb got %b want 0", stb_s); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy_s); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", done_s); end
        req = 1'b1; we = 1'b1; addr = 32'h0000_0080;
        @(negedge clk);
        rst_n = 1'b1;
        run(16, 1'b0);
        checks++; if (busy_a[0] !== 1'b1) begin errors++; $display("FAIL abort_first_accept got %b want 1", busy_a[0]); end
        for (int k = 0; k < 8; k++) begin
            logic [63:0] exp;
            exp = (k < 3) ? 64'(32'hC0 + k) : 64'(32'hA0 + k);
            checks++; if (tog_d[k] !== exp) begin errors++; $display("FAIL abort_line2[%0d] got %h want %h", k, tog_d[k], exp); end
        end
    endtask

    task automatic test_gap();
        sel = 1'b1;
        addr = 32'h0000_0040; we = 1'b1; req = 1'b1;
        run(27, 1'b0);
        checks++; if (ntog !== 8) begin errors++; $display("FAIL gap_toggles got %0d want 8", ntog); end
        for (int k = 0; k < 8; k++) begin
            checks++; if (tog_c[k] !== 1 + 3 * k) begin errors++; $display("FAIL gap_tog_cycle[%0d] got %0d want %0d", k, tog_c[k], 1 + 3 * k); end
            checks++; if (tog_d[k] !== 64'(8 + k)) begin errors++; $display("FAIL gap_data[%0d] got %h want %h", k, tog_d[k], 64'(8 + k)); end
        end
        checks++; if (busy_a[24] !== 1'b1) begin errors++; $display("FAIL gap_busy24 got %b want 1", busy_a[24]); end
        checks++; if (done_a[25] !== 1'b1) begin errors++; $display("FAIL gap_done25 got %b want 1", done_a[25]); end
        for (int k = 0; k < 8; k++) wbuf[k] = 64'(32'hD0 + k);
        addr = 32'h0000_00C0; we = 1'b0; tb_data = wbuf[0]; tb_drv = 1'b1; req = 1'b1;
        run(27, 1'b0);
        tb_drv = 1'b0;
        for (int k = 0; k < 8; k++) begin
            checks++; if (tog_d[k] !== 64'(32'hD0 + k)) begin errors++; $display("FAIL gap_wr_bus[%0d] got %h want %h", k, tog_d[k], 64'(32'hD0 + k)); end
        end
        addr = 32'h0000_00C0; we = 1'b1; req = 1'b1;
        run(27, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checks++; if (tog_d[k] !== 64'(32'hD0 + k)) begin errors++; $display("FAIL gap_readback[%0d] got %h want %h", k, tog_d[k], 64'(32'hD0 + k)); end
        end
        tb_data = MARK; tb_drv = 1'b1; #1;
        checks++; if (data1 !== MARK) begin errors++; $display("FAIL gap_bus_released got %h want %h", data1, MARK); end
        tb_drv = 1'b0;
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_critical_word();
        test_back_to_back();
        test_reset_mid_burst();
        test_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_burst_responder.md
MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 Parameter ACCESS_LATENCY, default 4: clock cycles from request accept to first beat (range 1..15).
REQ-002 Parameter BEAT_GAP, default 1: clock cycles between consecutive beats (range 1..7).
REQ-003 Parameter MEM_LINES_LOG2, default 8: log2 of stored 64-byte lines.
REQ-004 clk  input  1  single clock for the block; all flops on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req  input  1  level request from the cache side, sampled only in IDLE.
REQ-007 we_MEM  input  1  1 = read burst (memory to cache), 0 = write burst (cache to memory).
REQ-008 addr_MEM  input  32  byte address; line = addr_MEM[MEM_LINES_LOG2+5:6], beat = addr_MEM[5:3].
REQ-009 data_MEM  inout  64  burst data bus; driven only during read beats, else high-Z.
REQ-010 stb  output  1  beat strobe; every transition (either edge) marks one beat.
REQ-011 busy  output  1  high from accept through last beat.
REQ-012 done  output  1  one-cycle pulse after the final beat.

Function
REQ-013 Storage: 2^MEM_LINES_LOG2 x 8 words of 64 bits; no reset of contents; simulation init word[i] = i zero-extended.
REQ-014 FSM states IDLE, LATENCY, BEAT, DONE; reset state IDLE.
REQ-015 IDLE: req=1 at a clock edge latches addr_MEM, we_MEM, sets busy=1, loads latency counter, goes to LATENCY.
REQ-016 LATENCY: counts ACCESS_LATENCY cycles, then enters BEAT with beat counter 0; first stb toggle occurs exactly ACCESS_LATENCY cycles after the accepting edge.
REQ-017 BEAT: stb toggles once every BEAT_GAP cycles, exactly 8 toggles per burst; stb level therefore equals its pre-burst level after every complete burst.
REQ-018 Beat order: beat k of burst addresses word (k) of the latched line, 0..7 ascending (see REQ-027 for alternative).
REQ-019 Read: on the edge that toggles stb for beat k, data_MEM is updated to word k and held until next toggle; bus driven from first toggle until DONE entry, high-Z otherwise.
REQ-020 Write: on the edge that toggles stb for beat k, data_MEM is sampled into word k; initiator presents beat 0 before the first toggle and advances on each toggle.
REQ-021 After the 8th toggle plus BEAT_GAP cycles: DONE for one cycle, done=1, busy=0 in that cycle; then IDLE.
REQ-022 req held high or re-asserted during LATENCY/BEAT/DONE is ignored; a new burst is accepted no earlier than the first IDLE cycle after DONE.
REQ-023 Address bits [2:0] and bits above MEM_LINES_LOG2+5 ignored; line index wraps modulo 2^MEM_LINES_LOG2.

Reset
REQ-024 rst_n low: state IDLE, stb=0, busy=0, done=0, counters 0, data_MEM high-Z, immediately (asynchronous).
REQ-025 Reset mid-burst aborts with no done pulse; words already written by completed write beats remain; memory contents never cleared.
REQ-026 First request accepted on the first rising edge after rst_n deasserts with req=1.

Configuration
REQ-027 Macro MEM_CRITICAL_WORD_FIRST_EN: defined -> beat k accesses word (addr_MEM[5:3] + k) mod 8 for both reads and writes; undefined -> beat k accesses word k and addr_MEM[5:3] is ignored.

Verification
REQ-028 Reset, read req at addr 0x0000_0040, defaults -> first stb toggle 4 cycles after accept, data 0x8..0xF on 8 toggles, done at cycle 4+8, stb back to 0.
REQ-029 Write burst addr 0x0000_0080 data 0xA0..0xA7, then read same line -> read returns 0xA0..0xA7 in order.
REQ-030 MEM_CRITICAL_WORD_FIRST_EN, read addr 0x0000_0058 -> beats return words 0xB,0xC,0xD,0xE,0xF,0x8,0x9,0xA.
REQ-031 req held high continuously across two bursts -> second accept exactly one cycle after done; no overlap, stb toggles total 16.
REQ-032 rst_n low after 3rd beat of write to line 2 -> stb=0, busy=0, no done; subsequent read of line 2 shows words 0..2 new, 3..7 unchanged.
REQ-033 BEAT_GAP=3, ACCESS_LATENCY=1 -> toggles at cycles 1,4,...,22 after accept; data_MEM high-Z outside read beats.
